// File: rtl/gfx_mem_arbiter_if.sv
// gfx_mem_arbiter_if: bus bundle between the three write requesters, the
// arbiter and the memory bypass port. Requester index 0 = CPU, 1 = line
// engine, 2 = filler.
interface gfx_mem_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  last;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [31:0] din2;
    logic [3:0]  we0;
    logic [3:0]  we1;
    logic [3:0]  we2;
    logic        mem_ready;
    logic [2:0]  gnt;
    logic [2:0]  accept;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic        cpu_stall;
    logic        busy;

    // Requester/memory side: drives beats and readiness, observes grants.
    modport master (
        output req, last, addr0, addr1, addr2, din0, din1, din2,
               we0, we1, we2, mem_ready,
        input  gnt, accept, mem_addr, mem_din, mem_we, cpu_stall, busy
    );

    // Arbiter side.
    modport slave (
        input  req, last, addr0, addr1, addr2, din0, din1, din2,
               we0, we1, we2, mem_ready,
        output gnt, accept, mem_addr, mem_din, mem_we, cpu_stall, busy
    );
endinterface

// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: round-robin, burst-locked arbiter for the frame-buffer
// bypass write port. A grant is held until the owner's last beat, MAX_BURST
// accepted beats, or the owner dropping req; one idle cycle follows each
// release. Optional macro GFX_ARB_CPU_PRIORITY_EN gives the CPU (requester 0)
// absolute priority at arbitration; the other two still rotate via rr.
module gfx_mem_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    gfx_mem_arbiter_if.slave   io_bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_gnt;
    logic [2:0]         w_gnt_nxt;
    logic [1:0]         r_rr;
    logic [1:0]         w_rr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [2:0]         w_win;
    logic [2:0]         w_accept;
    logic [1:0]         w_owner;
    logic [1:0]         w_rr_after;
    logic               w_own_req;
    logic               w_own_last;
    logic               w_own_acc;
    logic               w_burst_full;
    logic               w_release;

    // Owner decode and release conditions while granted
    always_comb begin
        w_owner      = r_gnt[1] ? 2'd1 : (r_gnt[2] ? 2'd2 : 2'd0);
        w_rr_after   = (w_owner == 2'd2) ? 2'd0 : 2'(w_owner + 2'd1);
        w_accept     = r_gnt & io_bus.req & {3{io_bus.mem_ready}};
        w_own_req    = |(r_gnt & io_bus.req);
        w_own_last   = |(r_gnt & io_bus.last);
        w_own_acc    = |w_accept;
        w_cnt_inc    = CNT_W'(r_beat_cnt + CNT_W'(1));
        w_burst_full = (w_cnt_inc == CNT_W'(MAX_BURST));
        w_release    = (r_state == S_GRANT) &&
                       (!w_own_req || (w_own_acc && (w_own_last || w_burst_full)));
    end

    // Arbitration winner for the IDLE cycle
    always_comb begin
        w_win = 3'b000;
`ifdef GFX_ARB_CPU_PRIORITY_EN
        if (io_bus.req[0])           w_win = 3'b001;
        else if (r_rr == 2'd2) begin
            if (io_bus.req[2])       w_win = 3'b100;
            else if (io_bus.req[1])  w_win = 3'b010;
        end else begin
            if (io_bus.req[1])       w_win = 3'b010;
            else if (io_bus.req[2])  w_win = 3'b100;
        end
`else
        case (r_rr)
            2'd0: begin
                if (io_bus.req[0])      w_win = 3'b001;
                else if (io_bus.req[1]) w_win = 3'b010;
                else if (io_bus.req[2]) w_win = 3'b100;
            end
            2'd1: begin
                if (io_bus.req[1])      w_win = 3'b010;
                else if (io_bus.req[2]) w_win = 3'b100;
                else if (io_bus.req[0]) w_win = 3'b001;
            end
            default: begin
                if (io_bus.req[2])      w_win = 3'b100;
                else if (io_bus.req[0]) w_win = 3'b001;
                else if (io_bus.req[1]) w_win = 3'b010;
            end
        endcase
`endif
    end

    // State and registered grant/pointer/counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 3'b000;
            r_rr       <= 2'd0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr       <= w_rr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|io_bus.req) w_state_nxt = S_GRANT;
            S_GRANT: if (w_release)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: next register values plus the combinational port muxes
    always_comb begin
        w_gnt_nxt      = r_gnt;
        w_rr_nxt       = r_rr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = w_win;
                if (|io_bus.req) w_beat_cnt_nxt = '0;
            end
            S_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt = 3'b000;
                    w_rr_nxt  = w_rr_after;
                end else if (w_own_acc) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_gnt_nxt = 3'b000;
        endcase

        io_bus.gnt       = r_gnt;
        io_bus.accept    = w_accept;
        io_bus.busy      = (r_state == S_GRANT);
        io_bus.cpu_stall = io_bus.req[0] & ~w_accept[0];
        io_bus.mem_addr  = 32'h0;
        io_bus.mem_din   = 32'h0;
        io_bus.mem_we    = 4'h0;
        case (r_gnt)
            3'b001: begin
                io_bus.mem_addr = io_bus.addr0;
                io_bus.mem_din  = io_bus.din0;
                io_bus.mem_we   = w_own_acc ? io_bus.we0 : 4'h0;
            end
            3'b010: begin
                io_bus.mem_addr = io_bus.addr1;
                io_bus.mem_din  = io_bus.din1;
                io_bus.mem_we   = w_own_acc ? io_bus.we1 : 4'h0;
            end
            3'b100: begin
                io_bus.mem_addr = io_bus.addr2;
                io_bus.mem_din  = io_bus.din2;
                io_bus.mem_we   = w_own_acc ? io_bus.we2 : 4'h0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: vector table, corner-case sequences and a randomized
// run against an owner/pointer/beat-count reference model.
module tb_gfx_mem_arbiter;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gfx_mem_arbiter_if bus();
    gfx_mem_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner index (-1 idle), rr pointer, beats taken
    int m_owner;
    int m_rr;
    int m_cnt;

    // Last observed DUT outputs, for sequence-level checks
    logic [2:0]  o_gnt, o_acc;
    logic [3:0]  o_we;
    logic [31:0] o_addr;
    logic        o_stall, o_busy;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  last;
        logic        rdy;
        logic [2:0]  gnt;
        logic [2:0]  acc;
        logic [3:0]  we;
        logic        stall;
        logic        busy;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int rr);
`ifdef GFX_ARB_CPU_PRIORITY_EN
        if (r[0]) return 0;
        if (rr == 2) begin
            if (r[2]) return 2;
            if (r[1]) return 1;
        end else begin
            if (r[1]) return 1;
            if (r[2]) return 2;
        end
        return -1;
`else
        for (int k = 0; k < 3; k++)
            if (r[(rr + k) % 3]) return (rr + k) % 3;
        return -1;
`endif
    endfunction

    function automatic logic [31:0] req_addr(input int i);
        return (i == 0) ? bus.addr0 : (i == 1) ? bus.addr1 : bus.addr2;
    endfunction
    function automatic logic [31:0] req_din(input int i);
        return (i == 0) ? bus.din0 : (i == 1) ? bus.din1 : bus.din2;
    endfunction
    function automatic logic [3:0] req_we(input int i);
        return (i == 0) ? bus.we0 : (i == 1) ? bus.we1 : bus.we2;
    endfunction

    // One clock: drive, compare with the model mid-cycle, advance the model
    task automatic cycle(input logic r, input logic [2:0] rq, input logic [2:0] lst, input logic rdy);
        logic [2:0]  eg, ea;
        logic [31:0] e_addr, e_din;
        logic [3:0]  e_we;
        logic        e_stall;
        rst = r; bus.req = rq; bus.last = lst; bus.mem_ready = rdy;
        #2;
        eg      = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        ea      = (m_owner >= 0 && rq[m_owner] && rdy) ? eg : 3'b000;
        e_addr  = (m_owner < 0) ? 32'h0 : req_addr(m_owner);
        e_din   = (m_owner < 0) ? 32'h0 : req_din(m_owner);
        e_we    = (ea != 3'b000) ? req_we(m_owner) : 4'h0;
        e_stall = rq[0] && !ea[0];
        o_gnt = bus.gnt; o_acc = bus.accept; o_we = bus.mem_we;
        o_addr = bus.mem_addr; o_stall = bus.cpu_stall; o_busy = bus.busy;
        check("model_gnt",   32'(o_gnt),   32'(eg));
        check("model_acc",   32'(o_acc),   32'(ea));
        check("model_addr",  o_addr,       e_addr);
        check("model_din",   bus.mem_din,  e_din);
        check("model_we",    32'(o_we),    32'(e_we));
        check("model_stall", 32'(o_stall), 32'(e_stall));
        check("model_busy",  32'(o_busy),  32'(m_owner >= 0));
        if (r) begin
            m_owner = -1; m_rr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(rq, m_rr); m_cnt = 0;
        end else if (!rq[m_owner]) begin
            m_rr = (m_owner + 1) % 3; m_owner = -1;
        end else if (ea != 3'b000) begin
            m_cnt++;
            if (lst[m_owner] || m_cnt == int'(MB)) begin
                m_rr = (m_owner + 1) % 3; m_owner = -1;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] lst,
                                input logic rdy, input logic [2:0] g, input logic [2:0] a,
                                input logic [3:0] w, input logic s, input logic b,
                                input logic [31:0] ad);
        vec_t v;
        v.rst = r; v.req = rq; v.last = lst; v.rdy = rdy; v.gnt = g; v.acc = a;
        v.we = w; v.stall = s; v.busy = b; v.addr = ad;
        return v;
    endfunction

    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] A1 = 32'h1000_0100;
    localparam logic [31:0] A2 = 32'h2000_0200;

    initial begin
        logic        pat[5];
        logic [2:0]  hist[8];
        logic [2:0]  lst;
        int          nb, nw, b;

        rst = 1'b1;
        bus.req = 3'b000; bus.last = 3'b000; bus.mem_ready = 1'b1;
        bus.addr0 = A0; bus.din0 = 32'hDEAD_BEEF; bus.we0 = 4'hF;
        bus.addr1 = A1; bus.din1 = 32'h1111_1111; bus.we1 = 4'h3;
        bus.addr2 = A2; bus.din2 = 32'h2222_2222; bus.we2 = 4'hC;
        repeat (2) @(posedge clk);
        #1;
        m_owner = -1; m_rr = 0; m_cnt = 0;

        // Vector table: reset state, single CPU write, round-robin order
        vt.push_back(mk(1, 3'b001, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b001, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b001, 3'b111, 1, 3'b001, 3'b001, 4'hF, 0, 1, A0));
        vt.push_back(mk(0, 3'b000, 3'b111, 1, 3'b000, 3'b000, 4'h0, 0, 0, 32'h0));
        vt.push_back(mk(1, 3'b000, 3'b111, 1, 3'b000, 3'b000, 4'h0, 0, 0, 32'h0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 4'hF, 0, 1, A0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
`ifdef GFX_ARB_CPU_PRIORITY_EN
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 4'hF, 0, 1, A0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 4'hF, 0, 1, A0));
`else
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b010, 3'b010, 4'h3, 1, 1, A1));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b100, 3'b100, 4'hC, 1, 1, A2));
`endif
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 4'h0, 1, 0, 32'h0));
        vt.push_back(mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 4'hF, 0, 1, A0));
        vt.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 3'b000, 4'h0, 0, 0, 32'h0));

        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].req, vt[i].last, vt[i].rdy);
            check($sformatf("vec%0d_gnt", i),   32'(o_gnt),   32'(vt[i].gnt));
            check($sformatf("vec%0d_acc", i),   32'(o_acc),   32'(vt[i].acc));
            check($sformatf("vec%0d_we", i),    32'(o_we),    32'(vt[i].we));
            check($sformatf("vec%0d_stall", i), 32'(o_stall), 32'(vt[i].stall));
            check($sformatf("vec%0d_busy", i),  32'(o_busy),  32'(vt[i].busy));
            check($sformatf("vec%0d_addr", i),  o_addr,       vt[i].addr);
        end

        // Burst limit: filler capped at MB beats, then line engine after one bubble
        cycle(1, 3'b000, 3'b000, 1);
        nb = 0;
        cycle(0, 3'b100, 3'b000, 1);
        for (int c = 0; c < 8; c++) begin
            cycle(0, 3'b110, 3'b000, 1);
            if (o_gnt == 3'b100 && o_we != 4'h0) nb++;
            hist[c] = o_gnt;
        end
        check("burst_filler_beats", 32'(nb), 32'(MB));
        check("burst_bubble_gnt", 32'(hist[MB]), 32'h0);
        check("burst_next_owner", 32'(hist[MB+1]), 32'h2);
        cycle(0, 3'b000, 3'b000, 1);
        cycle(0, 3'b000, 3'b000, 1);

        // Backpressure: three-beat line burst with ready 1,0,0,1,1
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        cycle(1, 3'b000, 3'b000, 1);
        b = 0; nw = 0;
        bus.addr1 = A1;
        cycle(0, 3'b010, 3'b000, 1);
        for (int c = 0; c < 5; c++) begin
            bus.addr1 = A1 + 32'(4 * b);
            lst = (b == 2) ? 3'b010 : 3'b000;
            cycle(0, 3'b010, lst, pat[c]);
            if (o_acc[1]) begin
                nw++; b++;
            end
            if (!pat[c]) begin
                check("bp_hold_gnt", 32'(o_gnt), 32'h2);
                check("bp_no_write", 32'(o_we), 32'h0);
            end
        end
        check("bp_beats", 32'(nw), 32'd3);
        cycle(0, 3'b000, 3'b000, 1);
        check("bp_released", 32'(o_gnt), 32'h0);
        bus.addr1 = A1;

        // Abort: owner drops req mid-burst, release advances rr past it
        cycle(1, 3'b000, 3'b000, 1);
        cycle(0, 3'b010, 3'b000, 1);
        cycle(0, 3'b010, 3'b000, 1);
        cycle(0, 3'b010, 3'b000, 1);
        cycle(0, 3'b000, 3'b000, 1);
        check("abort_still_gnt", 32'(o_gnt), 32'h2);
        check("abort_no_write", 32'(o_we), 32'h0);
        cycle(0, 3'b111, 3'b000, 1);
        check("abort_bubble", 32'(o_gnt), 32'h0);
        cycle(0, 3'b111, 3'b111, 1);
`ifdef GFX_ARB_CPU_PRIORITY_EN
        check("abort_next_owner", 32'(o_gnt), 32'h1);
`else
        check("abort_next_owner", 32'(o_gnt), 32'h4);
`endif
        cycle(0, 3'b000, 3'b000, 1);
        cycle(0, 3'b000, 3'b000, 1);

        // Reset mid-burst: grant dropped, no write, rr back to 0
        cycle(1, 3'b000, 3'b000, 1);
        cycle(0, 3'b010, 3'b000, 1);
        cycle(0, 3'b010, 3'b000, 1);
        cycle(1, 3'b010, 3'b000, 1);
        cycle(0, 3'b111, 3'b000, 1);
        check("rst_gnt", 32'(o_gnt), 32'h0);
        check("rst_we", 32'(o_we), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        cycle(0, 3'b111, 3'b111, 1);
        check("rst_rr_zero", 32'(o_gnt), 32'h1);
        cycle(0, 3'b000, 3'b000, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [2:0] rq_r, ls_r;
            rq_r = 3'($urandom);
            ls_r = 3'($urandom) & 3'($urandom);
            bus.addr0 = $urandom; bus.addr1 = $urandom; bus.addr2 = $urandom;
            bus.din0  = $urandom; bus.din1  = $urandom; bus.din2  = $urandom;
            bus.we0 = 4'($urandom); bus.we1 = 4'($urandom); bus.we2 = 4'($urandom);
            cycle(($urandom_range(0, 63) == 0), rq_r, ls_r, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
